morse_letter_tx: RTL

- Morse transmitter stage: takes a 3-bit letter select (A–H) and a start request, then serialises that letter's Morse code onto a single output line (`tx`) as timed marks and spaces.
- Its output `tx` drives an LED and the morse pattern checker (the existing consecutive-0s/1s detector), which consumes `tx` as its `w` input stream.
- Timing is based on a unit tick derived from the board clock.
- Dot = 1 unit on; dash = 3 units on; intra-letter gap = 1 unit off.

---
 rtl/morse_pkg.sv | 37 +++
 rtl/morse_tick_gen.sv | 28 ++
 rtl/morse_letter_tx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared states, unit lengths and letter code table for the Morse transmitter
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        WGAP  = 2'd3
    } state_t;

    localparam logic [1:0] DOT_UNITS   = 2'd1;
    localparam logic [1:0] DASH_UNITS  = 2'd3;
    localparam logic [1:0] SPACE_UNITS = 2'd1;
    localparam logic [1:0] WGAP_UNITS  = 2'd3;

    typedef struct packed {
        logic [3:0] pattern;
        logic [2:0] len;
    } code_t;

    // Pattern is left-aligned: bit 3 is the first symbol, 1 = dash.
    function automatic code_t morse_code(input logic [2:0] letter);
        code_t c;
        case (letter)
            3'd0:    c = {4'b0100, 3'd2};
            3'd1:    c = {4'b1000, 3'd4};
            3'd2:    c = {4'b1010, 3'd4};
            3'd3:    c = {4'b1000, 3'd3};
            3'd4:    c = {4'b0000, 3'd1};
            3'd5:    c = {4'b0010, 3'd4};
            3'd6:    c = {4'b1100, 3'd3};
            default: c = {4'b0000, 3'd4};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// rtl/morse_tick_gen.sv - free-running Morse unit tick with synchronous clear
module morse_tick_gen #(
    parameter int TICK_CYCLES = 25000000,
    parameter int TICK_W      = $clog2(TICK_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_CYCLES - 1);

    logic [TICK_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/morse_letter_tx.sv
// rtl/morse_letter_tx.sv - serialises one Morse letter (A-H) onto tx; MORSE_REPEAT_EN adds word-gap repeat
module morse_letter_tx
    import morse_pkg::*;
#(
    parameter int TICK_CYCLES = 25000000,
    parameter int TICK_W      = $clog2(TICK_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] letter,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    state_t     state_q, state_d;
    logic [3:0] pat_q, pat_d;
    logic [2:0] len_q, len_d;
    logic [2:0] idx_q, idx_d;
    logic [1:0] unit_q, unit_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       tick;
    logic       clr;
    logic [1:0] mark_units;
    code_t      code;

    // Every state change restarts the unit timer so each phase is whole units long.
    assign clr = (state_d != state_q);

    morse_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES),
        .TICK_W     (TICK_W)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .tick (tick)
    );

    assign code       = morse_code(letter);
    assign mark_units = pat_q[3] ? DASH_UNITS : DOT_UNITS;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        unit_d  = unit_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != IDLE && tick) begin
            unit_d = unit_q + 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = code.pattern;
                    len_d   = code.len;
                    idx_d   = 3'd0;
                    unit_d  = 2'd0;
                    state_d = MARK;
                    tx_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            MARK: begin
                if (tick && unit_q == mark_units - 2'd1) begin
                    unit_d = 2'd0;
                    tx_d   = 1'b0;
                    if (idx_q == len_q - 3'd1) begin
                        done_d = 1'b1;
`ifdef MORSE_REPEAT_EN
                        if (start) begin
                            state_d = WGAP;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
`else
                        state_d = IDLE;
                        busy_d  = 1'b0;
`endif
                    end else begin
                        state_d = SPACE;
                    end
                end
            end
            SPACE: begin
                if (tick && unit_q == SPACE_UNITS - 2'd1) begin
                    unit_d  = 2'd0;
                    pat_d   = {pat_q[2:0], 1'b0};
                    idx_d   = idx_q + 3'd1;
                    state_d = MARK;
                    tx_d    = 1'b1;
                end
            end
`ifdef MORSE_REPEAT_EN
            WGAP: begin
                if (tick && unit_q == WGAP_UNITS - 2'd1) begin
                    unit_d = 2'd0;
                    if (start) begin
                        pat_d   = code.pattern;
                        len_d   = code.len;
                        idx_d   = 3'd0;
                        state_d = MARK;
                        tx_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
                unit_d  = 2'd0;
                tx_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pat_q   <= 4'd0;
            len_q   <= 3'd0;
            idx_q   <= 3'd0;
            unit_q  <= 2'd0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            unit_q  <= unit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
